// File: rtl/pic_port_bridge.sv
// pic_port_bridge
// Host-side bridge for the PIC16C57 port-signalling protocol.
// Pixels arrive on a valid/ready stream, are queued in a small FIFO and
// are presented on port B when the CPU signals READY. Results of
// 2*DATA_W bits are captured from ports B (high) and C (low) into a
// tagged output register, one channel per RESULT code.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   portAIO             signal code from the CPU
//   portBIO / portCIO   bidirectional data ports (high-Z while in RES)
//   pix_*               pixel input stream
//   frame_last          level, sampled on CHECK: no more pixels
//   res_*               result output stream (data, channel tag)
//   stall               READY is waiting on an empty FIFO
//   overflow            sticky, a result was dropped
//   done                END reached
module pic_port_bridge #(
    parameter int DATA_W     = 8,
    parameter int SIG_W      = 4,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter logic [SIG_W-1:0] SIG_READY   = 'h1,
    parameter logic [SIG_W-1:0] SIG_CHECK   = 'hA,
    parameter logic [SIG_W-1:0] SIG_RESULT0 = 'hD,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIG_W-1:0]    portAIO,
    inout  wire  [DATA_W-1:0]   portBIO,
    inout  wire  [DATA_W-1:0]   portCIO,
    input  logic [DATA_W-1:0]   pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic                frame_last,
    output logic [2*DATA_W-1:0] res_data,
    output logic [CH_W-1:0]     res_ch,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                stall,
    output logic                overflow,
    output logic                done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_INIT, S_READ, S_RES, S_END} state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_k;
    logic [SIG_W-1:0]    r_a_prev;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr, r_rd;
    logic [AW:0]         r_cnt;
    logic                r_stall, r_ovf, r_done, r_res_valid;
    logic [2*DATA_W-1:0] r_res_data;
    logic [CH_W-1:0]     r_res_ch;

    logic             w_evt, w_ready_ev, w_check_ev, w_res0_ev, w_next_ev;
    logic             w_last_ch, w_do_check, w_push, w_pop, w_direct, w_wr, w_cap;
    logic [SIG_W-1:0] w_next_code;

    assign w_evt       = (portAIO != r_a_prev);
    assign w_ready_ev  = w_evt && (portAIO == SIG_READY);
    assign w_check_ev  = w_evt && (portAIO == SIG_CHECK);
    assign w_res0_ev   = w_evt && (portAIO == SIG_RESULT0);
    assign w_last_ch   = (r_k == CH_W'(NUM_CH - 1));
    assign w_next_code = SIG_RESULT0 + SIG_W'(r_k) + SIG_W'(1);
    assign w_next_ev   = w_evt && (portAIO == w_next_code) && !w_last_ch;
    assign w_do_check  = w_check_ev &&
                         ((r_state == S_INIT) || ((r_state == S_RES) && w_last_ch));

    assign pix_ready = (r_cnt != (AW+1)'(FIFO_DEPTH));
    assign w_push    = pix_valid && pix_ready;
    assign w_pop     = (r_state == S_READ) && w_ready_ev && (r_cnt != '0);
    // A push goes straight to B when a READY is already waiting, or when
    // it coincides with a READY that finds the FIFO empty.
    assign w_direct  = w_push && (r_stall ||
                       ((r_state == S_READ) && w_ready_ev && (r_cnt == '0)));
    assign w_wr      = w_push && !w_direct;
    assign w_cap     = (r_state == S_RES) && w_ready_ev;

    assign portBIO   = (r_state == S_RES) ? {DATA_W{1'bz}} : r_b;
    assign portCIO   = (r_state == S_RES) ? {DATA_W{1'bz}} : {DATA_W{1'b0}};

    assign res_data  = r_res_data;
    assign res_ch    = r_res_ch;
    assign res_valid = r_res_valid;
    assign stall     = r_stall;
    assign overflow  = r_ovf;
    assign done      = r_done;

    // Storage array carries no reset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= pix_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_INIT;
            r_k         <= '0;
            r_a_prev    <= '0;
            r_b         <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_stall     <= 1'b0;
            r_ovf       <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_ch    <= '0;
        end else begin
            r_a_prev <= portAIO;

            if (w_wr && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_wr && w_pop) r_cnt <= r_cnt - 1'b1;
            if (w_wr)  r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;

            if (w_direct) begin
                r_b     <= pix_data;
                r_stall <= 1'b0;
            end

            case (r_state)
                S_INIT: ;
                S_READ: begin
                    if (w_ready_ev) begin
                        if (r_cnt != '0)  r_b     <= r_mem[r_rd];
                        else if (!w_push) r_stall <= 1'b1;
                    end else if (w_res0_ev) begin
                        r_state <= S_RES;
                        r_k     <= '0;
                        // The pending READY is abandoned once results start.
                        r_stall <= 1'b0;
                    end
                end
                S_RES: if (w_next_ev) r_k <= r_k + 1'b1;
                S_END: ;
                default: r_state <= S_INIT;
            endcase

            if (w_do_check) begin
                r_b     <= frame_last ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
                r_state <= frame_last ? S_END : S_READ;
                r_done  <= frame_last;
            end

            // Output register: a capture reloads even as the old word is
            // accepted; it is only dropped when the old word is stuck.
            if (w_cap) begin
                if (r_res_valid && !res_ready) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_res_data  <= {portBIO, portCIO};
                    r_res_ch    <= r_k;
                    r_res_valid <= 1'b1;
                end
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pic_port_bridge.sv
module tb_pic_port_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  a = '0;
    logic [7:0]  pd = '0, tb_b = '0, tb_c = '0;
    logic        pv = 1'b0, fl = 1'b0, rr = 1'b1, den = 1'b0;
    wire  [7:0]  portB, portC;
    logic        pix_ready, res_valid, stall, overflow, done;
    logic [15:0] res_data;
    logic [1:0]  res_ch;
    int          total = 0, bad = 0;

    assign portB = den ? tb_b : 8'bz;
    assign portC = den ? tb_c : 8'bz;

    always #5 clk = ~clk;

    pic_port_bridge #(.DATA_W(8), .SIG_W(4), .NUM_CH(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .portAIO(a), .portBIO(portB), .portCIO(portC),
        .pix_data(pd), .pix_valid(pv), .pix_ready(pix_ready), .frame_last(fl),
        .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid),
        .res_ready(rr), .stall(stall), .overflow(overflow), .done(done)
    );

    typedef struct {
        logic [3:0] a; bit fl, pv; logic [7:0] pd; bit rr, den; logic [7:0] db, dc;
        bit chkb; logic [7:0] eb; bit est, erv; logic [15:0] erd; logic [1:0] ech;
        bit eov, edn, epr;
    } vec_t;

    function automatic vec_t v(logic [3:0] a_, bit fl_, bit pv_, logic [7:0] pd_,
                               bit rr_, bit den_, logic [7:0] db_, logic [7:0] dc_,
                               bit chkb_, logic [7:0] eb_, bit est_, bit erv_,
                               logic [15:0] erd_, logic [1:0] ech_, bit eov_,
                               bit edn_, bit epr_);
        vec_t r;
        r.a = a_; r.fl = fl_; r.pv = pv_; r.pd = pd_; r.rr = rr_; r.den = den_;
        r.db = db_; r.dc = dc_; r.chkb = chkb_; r.eb = eb_; r.est = est_;
        r.erv = erv_; r.erd = erd_; r.ech = ech_; r.eov = eov_; r.edn = edn_;
        r.epr = epr_;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".b"},     32'(portB), 32'h00);
        chk({tag, ".c"},     32'(portC), 32'h00);
        chk({tag, ".rv"},    32'(res_valid), 32'd0);
        chk({tag, ".rd"},    32'(res_data), 32'h0000);
        chk({tag, ".ch"},    32'(res_ch), 32'd0);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".ovf"},   32'(overflow), 32'd0);
        chk({tag, ".done"},  32'(done), 32'd0);
        chk({tag, ".prdy"},  32'(pix_ready), 32'd1);
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rise.
    task automatic cyc(input logic [3:0] a_, input bit fl_, input bit pv_,
                       input logic [7:0] pd_, input bit rr_, input bit den_,
                       input logic [7:0] db_, input logic [7:0] dc_);
        @(negedge clk);
        a = a_; fl = fl_; pv = pv_; pd = pd_; rr = rr_; den = den_; tb_b = db_; tb_c = dc_;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[43];

    initial begin
        // a, fl, pv, pd, rr, den, db, dc | chkb, eb, stall, rv, rd, ch, ovf, done, prdy
        tbl[0]  = v(4'h0,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h00,0,0,16'h0000,2'd0,0,0,1);
        tbl[1]  = v(4'hA,0,1,8'h37,1,0,8'h00,8'h00, 1,8'h00,0,0,16'h0000,2'd0,0,0,1);
        tbl[2]  = v(4'h1,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h37,0,0,16'h0000,2'd0,0,0,1);
        tbl[3]  = v(4'h0,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h37,0,0,16'h0000,2'd0,0,0,1);
        tbl[4]  = v(4'h1,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h37,1,0,16'h0000,2'd0,0,0,1);
        tbl[5]  = v(4'h1,0,1,8'h5C,1,0,8'h00,8'h00, 1,8'h5C,0,0,16'h0000,2'd0,0,0,1);
        tbl[6]  = v(4'h1,0,1,8'h01,1,0,8'h00,8'h00, 1,8'h5C,0,0,16'h0000,2'd0,0,0,1);
        tbl[7]  = v(4'h1,0,1,8'h02,1,0,8'h00,8'h00, 1,8'h5C,0,0,16'h0000,2'd0,0,0,1);
        tbl[8]  = v(4'h1,0,1,8'h03,1,0,8'h00,8'h00, 1,8'h5C,0,0,16'h0000,2'd0,0,0,1);
        tbl[9]  = v(4'h1,0,1,8'h04,1,0,8'h00,8'h00, 1,8'h5C,0,0,16'h0000,2'd0,0,0,0);
        tbl[10] = v(4'h1,0,1,8'h05,1,0,8'h00,8'h00, 1,8'h5C,0,0,16'h0000,2'd0,0,0,0);
        tbl[11] = v(4'h0,0,1,8'h05,1,0,8'h00,8'h00, 1,8'h5C,0,0,16'h0000,2'd0,0,0,0);
        tbl[12] = v(4'h1,0,1,8'h05,1,0,8'h00,8'h00, 1,8'h01,0,0,16'h0000,2'd0,0,0,1);
        tbl[13] = v(4'h0,0,1,8'h05,1,0,8'h00,8'h00, 1,8'h01,0,0,16'h0000,2'd0,0,0,0);
        tbl[14] = v(4'h1,0,1,8'h06,1,0,8'h00,8'h00, 1,8'h02,0,0,16'h0000,2'd0,0,0,1);
        tbl[15] = v(4'h0,0,1,8'h06,1,0,8'h00,8'h00, 1,8'h02,0,0,16'h0000,2'd0,0,0,0);
        tbl[16] = v(4'h1,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h03,0,0,16'h0000,2'd0,0,0,1);
        tbl[17] = v(4'h0,0,1,8'h07,1,0,8'h00,8'h00, 1,8'h03,0,0,16'h0000,2'd0,0,0,0);
        tbl[18] = v(4'h1,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h04,0,0,16'h0000,2'd0,0,0,1);
        tbl[19] = v(4'h0,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h04,0,0,16'h0000,2'd0,0,0,1);
        tbl[20] = v(4'h1,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h05,0,0,16'h0000,2'd0,0,0,1);
        tbl[21] = v(4'h0,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h05,0,0,16'h0000,2'd0,0,0,1);
        tbl[22] = v(4'h1,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h06,0,0,16'h0000,2'd0,0,0,1);
        tbl[23] = v(4'h0,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h06,0,0,16'h0000,2'd0,0,0,1);
        tbl[24] = v(4'h1,0,1,8'h08,1,0,8'h00,8'h00, 1,8'h07,0,0,16'h0000,2'd0,0,0,1);
        tbl[25] = v(4'h0,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h07,0,0,16'h0000,2'd0,0,0,1);
        tbl[26] = v(4'h1,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h08,0,0,16'h0000,2'd0,0,0,1);
        tbl[27] = v(4'hD,0,0,8'h00,1,0,8'h00,8'h00, 0,8'h00,0,0,16'h0000,2'd0,0,0,1);
        tbl[28] = v(4'h1,0,0,8'h00,0,1,8'h12,8'h34, 0,8'h00,0,1,16'h1234,2'd0,0,0,1);
        tbl[29] = v(4'h0,0,0,8'h00,0,1,8'h12,8'h34, 0,8'h00,0,1,16'h1234,2'd0,0,0,1);
        tbl[30] = v(4'h1,0,0,8'h00,0,1,8'h99,8'h99, 0,8'h00,0,1,16'h1234,2'd0,1,0,1);
        tbl[31] = v(4'hE,0,0,8'h00,1,1,8'h99,8'h99, 0,8'h00,0,0,16'h1234,2'd0,1,0,1);
        tbl[32] = v(4'h1,0,0,8'h00,1,1,8'hAB,8'hCD, 0,8'h00,0,1,16'hABCD,2'd1,1,0,1);
        tbl[33] = v(4'hF,0,0,8'h00,1,1,8'hAB,8'hCD, 0,8'h00,0,0,16'hABCD,2'd1,1,0,1);
        tbl[34] = v(4'h1,0,0,8'h00,0,1,8'h00,8'h01, 0,8'h00,0,1,16'h0001,2'd2,1,0,1);
        tbl[35] = v(4'hA,0,0,8'h00,1,0,8'h00,8'h00, 1,8'h00,0,0,16'h0001,2'd2,1,0,1);
        tbl[36] = v(4'hD,0,0,8'h00,1,0,8'h00,8'h00, 0,8'h00,0,0,16'h0001,2'd2,1,0,1);
        tbl[37] = v(4'hA,1,0,8'h00,1,0,8'h00,8'h00, 0,8'h00,0,0,16'h0001,2'd2,1,0,1);
        tbl[38] = v(4'hE,1,0,8'h00,1,0,8'h00,8'h00, 0,8'h00,0,0,16'h0001,2'd2,1,0,1);
        tbl[39] = v(4'hF,1,0,8'h00,1,0,8'h00,8'h00, 0,8'h00,0,0,16'h0001,2'd2,1,0,1);
        tbl[40] = v(4'hA,1,0,8'h00,1,0,8'h00,8'h00, 1,8'hFF,0,0,16'h0001,2'd2,1,1,1);
        tbl[41] = v(4'h1,1,0,8'h00,1,0,8'h00,8'h00, 1,8'hFF,0,0,16'h0001,2'd2,1,1,1);
        tbl[42] = v(4'hD,1,0,8'h00,1,0,8'h00,8'h00, 1,8'hFF,0,0,16'h0001,2'd2,1,1,1);

        // Reset held low.
        #12;
        chk_reset("rst0");
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].a, tbl[i].fl, tbl[i].pv, tbl[i].pd, tbl[i].rr, tbl[i].den,
                tbl[i].db, tbl[i].dc);
            if (tbl[i].chkb) begin
                chk($sformatf("v%0d.b", i), 32'(portB), 32'(tbl[i].eb));
                chk($sformatf("v%0d.c", i), 32'(portC), 32'h00);
            end
            chk($sformatf("v%0d.stall", i), 32'(stall), 32'(tbl[i].est));
            chk($sformatf("v%0d.rv", i), 32'(res_valid), 32'(tbl[i].erv));
            chk($sformatf("v%0d.rd", i), 32'(res_data), 32'(tbl[i].erd));
            chk($sformatf("v%0d.ch", i), 32'(res_ch), 32'(tbl[i].ech));
            chk($sformatf("v%0d.ovf", i), 32'(overflow), 32'(tbl[i].eov));
            chk($sformatf("v%0d.done", i), 32'(done), 32'(tbl[i].edn));
            chk($sformatf("v%0d.prdy", i), 32'(pix_ready), 32'(tbl[i].epr));
        end

        // Asynchronous reset out of END, between clock edges.
        @(negedge clk);
        a = 4'h0; den = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset("rst_end");
        @(negedge clk);
        rst = 1'b1;

        // Back-pressure relieved on the second capture edge: no loss.
        cyc(4'hA, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk("bp.init_b", 32'(portB), 32'h00);
        cyc(4'hD, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        cyc(4'h1, 0, 0, 8'h00, 0, 1, 8'h11, 8'h22);
        chk("bp.rv1", 32'(res_valid), 32'd1);
        chk("bp.rd1", 32'(res_data), 32'h1122);
        cyc(4'h0, 0, 0, 8'h00, 0, 1, 8'h11, 8'h22);
        chk("bp.hold", 32'(res_data), 32'h1122);
        cyc(4'h1, 0, 0, 8'h00, 1, 1, 8'h33, 8'h44);
        chk("bp.rv2", 32'(res_valid), 32'd1);
        chk("bp.rd2", 32'(res_data), 32'h3344);
        chk("bp.ch2", 32'(res_ch), 32'd0);
        chk("bp.ovf", 32'(overflow), 32'd0);

        // Reset pulse mid-RES: ports driven 0 at once, pending result gone.
        @(negedge clk);
        den = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset("rst_res");
        @(negedge clk);
        rst = 1'b1;

        // Back in INIT: CHECK with frame_last ends the frame.
        cyc(4'hA, 1, 0, 8'h00, 1, 0, 8'h00, 8'h00);
        chk("post.b", 32'(portB), 32'hFF);
        chk("post.done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pic_port_bridge.md
# pic_port_bridge

Synthesizable host-side bridge for the PIC16C57 port-signalling protocol. It replaces the behavioural pixel/result exchange with a streaming interface: pixels enter through a valid/ready FIFO and go out on port B; multi-channel 2·DATA_W results are captured from ports B/C into a tagged output stream. It sits between the image pipeline and `PIC16C57` and is parametrised in data width, result channel count and FIFO depth. It adds stall-on-empty, back-pressure and overflow reporting.

## Interface
- `DATA_W`, 8: width of port B and port C, and of each pixel.
- `SIG_W`, 4: width of port A.
- `NUM_CH`, 2: result channels (1..4). Channel k is announced by code `SIG_RESULT0 + k`.
- `FIFO_DEPTH`, 4: pixel FIFO entries, a power of two ≥ 2.
- `SIG_READY`, 4'h1; `SIG_CHECK`, 4'hA; `SIG_RESULT0`, 4'hD: port-A codes.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `portAIO` in SIG_W: signal code from the CPU.
- `portBIO` inout DATA_W: pixel or check value out; result high half in.
- `portCIO` inout DATA_W: driven 0; result low half in.
- `pix_data` in DATA_W, `pix_valid` in 1, `pix_ready` out 1: pixel input stream.
- `frame_last` in 1: level input, sampled on CHECK. High means no more pixels.
- `res_data` out 2·DATA_W, `res_ch` out clog2(NUM_CH) (minimum 1 bit), `res_valid` out 1, `res_ready` in 1: result output stream.
- `stall` out 1: a READY request is waiting on an empty FIFO.
- `overflow` out 1: sticky. A result was lost.
- `done` out 1: the END stage has been reached.

## Operation
- States: INIT, READ, RES(k), END. The RES state holds an internal channel index k.
- Event detection: `a_prev` register, reset to 0. An event occurs on any edge where `portAIO != a_prev`. On that edge `a_prev <= portAIO` and the event is processed. If the code does not change, no event occurs.
- INIT, CHECK event: sample `frame_last`. If high, drive B = all-ones and go to END. If low, drive B = 0 and go to READ.
- READ, READY event: if the FIFO is non-empty, pop it to B. If it is empty, set `stall`. While `stall` is set, the first pushed word goes straight to B (no FIFO write) and `stall` clears.
- READ, `SIG_RESULT0` event: go to RES(0).
- RES(k), READY event: capture {B, C} into the output register with `res_ch = k`. If `res_valid` is already 1 and `res_ready` is 0, the new word is dropped and `overflow` is set.
- RES(k), code `SIG_RESULT0 + k + 1` (with k+1 < NUM_CH): go to RES(k+1).
- RES(NUM_CH−1), CHECK event: same as the INIT CHECK event.
- Any other code in any state is ignored apart from the `a_prev` update.
- Port drive: B and C are high-Z in RES(k), and driven in every other state.
- FIFO: standard circular buffer with a `count` field.
  - `pix_ready = (count < FIFO_DEPTH)`.
  - A push and a pop on the same edge leave `count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output register: `res_valid` clears on `res_valid && res_ready`. A simultaneous capture reloads it, so the accepted word is replaced by the new one and nothing is lost.
- END: all events are ignored and `done = 1`. Only reset leaves END.

## Timing
- Reset values:
  - state INIT
  - `a_prev` = 0; B drive value 0; C = 0
  - FIFO empty; `pix_ready` = 1
  - `res_valid` = 0, `res_data` = 0, `res_ch` = 0
  - `stall`, `overflow`, `done` = 0
- Event latency:
  - port A change sampled at edge N updates B at edge N, so B is visible after edge N.
  - A result captured at edge N gives `res_valid` high after edge N.
- Stall release: a push at edge M drives B at edge M and `stall` drops at edge M.
- Reset mid-operation: asynchronous and immediate. FIFO contents and the pending result are discarded, and B/C return to driven 0 at once.

## Test plan
- Reset/INIT:
  - hold `rst` = 0 → all outputs at their reset values.
  - release `rst`; `frame_last` = 0; A = A → B = 00 and state READ.
  - A = 1 with FIFO holding 0x37 → B = 0x37 one edge later.
- Stall:
  - FIFO empty, A = 1 → `stall` = 1, B unchanged.
  - push 0x5C → B = 0x5C and `stall` = 0 on the same edge; `count` stays 0.
- Multi-channel, NUM_CH = 3:
  - sequence D, 1(B = 12, C = 34), E, 1(B = AB, C = CD), F, 1(B = 00, C = 01), `res_ready` = 1.
  - required outputs: 0x1234/ch0, 0xABCD/ch1, 0x0001/ch2.
- Back-pressure:
  - `res_ready` = 0 with two READY events in RES(0) → first word held, `overflow` = 1.
  - same case with `res_ready` = 1 on the second capture edge → second word valid, `overflow` stays 0.
- FIFO full/wrap:
  - FIFO_DEPTH = 4: push 5 words → `pix_ready` = 0 after the fourth push.
  - 6 pops interleaved with pushes → FIFO order is preserved across the pointer wrap.
- End and reset:
  - CHECK with `frame_last` = 1 → B = FF and `done` = 1; further codes are ignored.
  - pulse `rst` low mid-RES → state INIT and B driven 00 immediately.
